// File: rtl/flop_write_arbiter.sv
// flop_write_arbiter: round-robin arbiter feeding one shared enable-gated register (d/en) from N_REQ requesters
//   clk    : rising-edge clock
//   rst    : synchronous reset, active-low
//   req    : per-requester write request
//   lock   : per-requester burst request (qualified by req)
//   data   : requester words, slice i = data[i*WIDTH +: WIDTH]
//   stall  : downstream busy, no grant decided while high
//   gnt    : registered one-hot grant
//   gnt_id : index of current/last grantee
//   d_out  : registered granted word to shared register d
//   en_out : shared register enable, equals |gnt
module flop_write_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int MAX_BURST = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         lock,
  input  logic [N_REQ*WIDTH-1:0]   data,
  input  logic                     stall,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic [WIDTH-1:0]         d_out,
  output logic                     en_out
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic [1:0] {IDLE, GRANT, BURST} state_t;
  state_t        state;
  logic [IW-1:0] ptr;
  logic [CW-1:0] burst_cnt;
  logic          held;
  logic          found;
  logic [IW-1:0] win;
  logic          cont;
  // ptr always equals last grantee + 1, so an exhausted burst searching from
  // ptr naturally starts at g+1 and still lets a lone requester win again.
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N_REQ]) begin
        found = 1'b1;
        win = IW'((int'(ptr) + k) % N_REQ);
      end
    end
  end
  // held keeps burst continuity across a stall, where state is forced to IDLE
  assign cont = (state != IDLE || held) && req[gnt_id] && lock[gnt_id] &&
                burst_cnt < CW'(MAX_BURST - 1);
  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt <= '0;
      en_out <= 1'b0;
      d_out <= '0;
      gnt_id <= '0;
      ptr <= '0;
      burst_cnt <= '0;
      held <= 1'b0;
      state <= IDLE;
    end else if (stall) begin
      gnt <= '0;
      en_out <= 1'b0;
      held <= held || state != IDLE;
      state <= IDLE;
    end else if (cont) begin
      gnt <= N_REQ'(1) << gnt_id;
      en_out <= 1'b1;
      d_out <= data[gnt_id*WIDTH +: WIDTH];
      burst_cnt <= burst_cnt + 1'b1;
      held <= 1'b0;
      state <= BURST;
    end else if (found) begin
      gnt <= N_REQ'(1) << win;
      en_out <= 1'b1;
      d_out <= data[win*WIDTH +: WIDTH];
      gnt_id <= win;
      ptr <= int'(win) == N_REQ - 1 ? '0 : win + 1'b1;
      burst_cnt <= '0;
      held <= 1'b0;
      state <= lock[win] ? BURST : GRANT;
    end else begin
      gnt <= '0;
      en_out <= 1'b0;
      held <= 1'b0;
      state <= IDLE;
    end
  end
endmodule
